// File: rtl/tlv5638_scheduler_if.sv
// Sample/config offer and serializer handshake bundle for tlv5638_scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface tlv5638_scheduler_if;
  logic        a_valid;
  logic [11:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [11:0] b_data;
  logic        b_ready;
  logic        cfg_valid;
  logic [1:0]  cfg_ref;
  logic        cfg_spd;
  logic        cfg_pwr;
  logic        cfg_ready;
  logic [15:0] wr_word;
  logic        wr_valid;
  logic        wr_ready;
  logic        init_done;
  logic        busy;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    output cfg_valid, cfg_ref, cfg_spd, cfg_pwr, wr_ready,
    input  a_ready, b_ready, cfg_ready, wr_word, wr_valid, init_done, busy
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    input  cfg_valid, cfg_ref, cfg_spd, cfg_pwr, wr_ready,
    output a_ready, b_ready, cfg_ready, wr_word, wr_valid, init_done, busy
  );
endinterface

// File: rtl/tlv5638_scheduler.sv
// TLV5638 command scheduler: turns A/B samples and control rewrites into 16-bit DAC words.
// Macro TLV_SCHED_PAIR_EN: both-pending A/B go out as BUF then A; otherwise round-robin singles.
module tlv5638_scheduler #(
  parameter logic [1:0] INIT_REF = 2'b10,
  parameter logic       INIT_SPD = 1'b1,
  parameter logic       INIT_PWR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  tlv5638_scheduler_if.slave bus
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CTRL, S_WB, S_WBUF, S_WA} state_t;

  state_t      state_q, state_d;
  logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d, pend_cfg_q, pend_cfg_d;
  logic [11:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic [1:0]  new_ref_q, new_ref_d;
  logic        new_spd_q, new_spd_d, new_pwr_q, new_pwr_d;
  logic [1:0]  ref_q, ref_d;
  logic        spd_q, spd_d, pwr_q, pwr_d;
  logic        wr_valid_q, wr_valid_d, busy_q, busy_d, init_done_q, init_done_d;
  logic [15:0] wr_word_q, wr_word_d;
  logic        xfer;
`ifndef TLV_SCHED_PAIR_EN
  logic        rr_b_q, rr_b_d;  // next contested grant goes to B
`endif

  function automatic logic [15:0] ctrl_word(input logic sp, input logic pw, input logic [1:0] rf);
    return {1'b1, sp, pw, 1'b1, 10'b0, rf};
  endfunction

  function automatic logic [15:0] data_word(input logic d15, input logic d12, input logic sp,
                                            input logic pw, input logic [11:0] data);
    return {d15, sp, pw, d12, data};
  endfunction

  assign xfer = wr_valid_q & bus.wr_ready;

  always_comb begin
    state_d     = state_q;
    pend_a_d    = pend_a_q;
    pend_b_d    = pend_b_q;
    pend_cfg_d  = pend_cfg_q;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    new_ref_d   = new_ref_q;
    new_spd_d   = new_spd_q;
    new_pwr_d   = new_pwr_q;
    ref_d       = ref_q;
    spd_d       = spd_q;
    pwr_d       = pwr_q;
    wr_valid_d  = wr_valid_q;
    wr_word_d   = wr_word_q;
    init_done_d = init_done_q;
`ifndef TLV_SCHED_PAIR_EN
    rr_b_d      = rr_b_q;
`endif

    if (bus.a_valid && !pend_a_q) begin
      pend_a_d = 1'b1;
      a_data_d = bus.a_data;
    end
    if (bus.b_valid && !pend_b_q) begin
      pend_b_d = 1'b1;
      b_data_d = bus.b_data;
    end
    if (bus.cfg_valid && !pend_cfg_q) begin
      pend_cfg_d = 1'b1;
      new_ref_d  = bus.cfg_ref;
      new_spd_d  = bus.cfg_spd;
      new_pwr_d  = bus.cfg_pwr;
    end

    case (state_q)
      S_INIT: begin
        // Reset leaves wr_valid low, so the power-up word is loaded one cycle later
        if (!wr_valid_q) begin
          wr_valid_d = 1'b1;
          wr_word_d  = ctrl_word(INIT_SPD, INIT_PWR, INIT_REF);
        end else if (xfer) begin
          wr_valid_d  = 1'b0;
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (pend_cfg_q) begin
          state_d    = S_CTRL;
          wr_valid_d = 1'b1;
          wr_word_d  = ctrl_word(new_spd_q, new_pwr_q, new_ref_q);
        end else if (pend_a_q && pend_b_q) begin
          wr_valid_d = 1'b1;
`ifdef TLV_SCHED_PAIR_EN
          state_d    = S_WBUF;
          wr_word_d  = data_word(1'b0, 1'b1, spd_q, pwr_q, b_data_q);
`else
          rr_b_d = ~rr_b_q;
          if (rr_b_q) begin
            state_d   = S_WB;
            wr_word_d = data_word(1'b0, 1'b0, spd_q, pwr_q, b_data_q);
          end else begin
            state_d   = S_WA;
            wr_word_d = data_word(1'b1, 1'b0, spd_q, pwr_q, a_data_q);
          end
`endif
        end else if (pend_a_q) begin
          state_d    = S_WA;
          wr_valid_d = 1'b1;
          wr_word_d  = data_word(1'b1, 1'b0, spd_q, pwr_q, a_data_q);
        end else if (pend_b_q) begin
          state_d    = S_WB;
          wr_valid_d = 1'b1;
          wr_word_d  = data_word(1'b0, 1'b0, spd_q, pwr_q, b_data_q);
        end
      end
      S_CTRL: begin
        if (xfer) begin
          ref_d      = new_ref_q;
          spd_d      = new_spd_q;
          pwr_d      = new_pwr_q;
          pend_cfg_d = 1'b0;
          wr_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_WB: begin
        if (xfer) begin
          pend_b_d   = 1'b0;
          wr_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_WBUF: begin
        // A follows the buffer word with no gap so both outputs update together
        if (xfer) begin
          pend_b_d  = 1'b0;
          wr_word_d = data_word(1'b1, 1'b0, spd_q, pwr_q, a_data_q);
          state_d   = S_WA;
        end
      end
      S_WA: begin
        if (xfer) begin
          pend_a_d   = 1'b0;
          wr_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_INIT;
        wr_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      pend_a_q    <= 1'b0;
      pend_b_q    <= 1'b0;
      pend_cfg_q  <= 1'b0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      new_ref_q   <= INIT_REF;
      new_spd_q   <= INIT_SPD;
      new_pwr_q   <= INIT_PWR;
      ref_q       <= INIT_REF;
      spd_q       <= INIT_SPD;
      pwr_q       <= INIT_PWR;
      wr_valid_q  <= 1'b0;
      wr_word_q   <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
`ifndef TLV_SCHED_PAIR_EN
      rr_b_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      pend_cfg_q  <= pend_cfg_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      new_ref_q   <= new_ref_d;
      new_spd_q   <= new_spd_d;
      new_pwr_q   <= new_pwr_d;
      ref_q       <= ref_d;
      spd_q       <= spd_d;
      pwr_q       <= pwr_d;
      wr_valid_q  <= wr_valid_d;
      wr_word_q   <= wr_word_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
`ifndef TLV_SCHED_PAIR_EN
      rr_b_q      <= rr_b_d;
`endif
    end
  end

  assign bus.a_ready   = ~pend_a_q;
  assign bus.b_ready   = ~pend_b_q;
  assign bus.cfg_ready = ~pend_cfg_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_word   = wr_word_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_tlv5638_scheduler.sv
// Randomized self-checking bench for tlv5638_scheduler; expected DAC words come from a
// word-level model of the command rules (priority, pairing/round-robin, config tracking).
`timescale 1ns/1ps
module tb_tlv5638_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  tlv5638_scheduler_if bus();

  tlv5638_scheduler #(.INIT_REF(2'b10), .INIT_SPD(1'b1), .INIT_PWR(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Transfers observed on the serializer side, sampled mid-cycle
  logic [15:0] got_q[$];
  int          got_cyc[$];
  always @(negedge clk) begin
    if (rst && bus.wr_valid && bus.wr_ready) begin
      got_q.push_back(bus.wr_word);
      got_cyc.push_back(cycle);
      $display("xfer cycle=%0d word=%h", cycle, bus.wr_word);
    end
  end

  // Reference model state
  logic [1:0]  m_ref;
  logic        m_spd, m_pwr;
  bit          m_rr_b;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] m_data(input int base, input logic [11:0] d);
    return 16'(base + (m_spd ? 16'h4000 : 16'h0) + (m_pwr ? 16'h2000 : 16'h0) + int'(d));
  endfunction

  function automatic logic [15:0] m_ctrl(input logic sp, input logic pw, input logic [1:0] rf);
    return 16'(16'h9000 + (sp ? 16'h4000 : 16'h0) + (pw ? 16'h2000 : 16'h0) + int'(rf));
  endfunction

  task automatic model_reset();
    m_ref = 2'b10; m_spd = 1'b1; m_pwr = 1'b0; m_rr_b = 1'b0;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    exp_q.push_back(m_ctrl(m_spd, m_pwr, m_ref));
  endtask

  // A word base 8000, B base 0000, BUF base 1000
  task automatic model_offer(input bit dc, input logic [1:0] cr, input logic cs, input logic cp,
                             input bit da, input logic [11:0] ad, input bit db, input logic [11:0] bd);
    if (dc) begin
      exp_q.push_back(m_ctrl(cs, cp, cr));
      m_ref = cr; m_spd = cs; m_pwr = cp;
    end
    if (da && db) begin
`ifdef TLV_SCHED_PAIR_EN
      exp_q.push_back(m_data(16'h1000, bd));
      exp_q.push_back(m_data(16'h8000, ad));
`else
      if (m_rr_b) begin
        exp_q.push_back(m_data(16'h0000, bd));
        exp_q.push_back(m_data(16'h8000, ad));
      end else begin
        exp_q.push_back(m_data(16'h8000, ad));
        exp_q.push_back(m_data(16'h0000, bd));
      end
      m_rr_b = !m_rr_b;
`endif
    end else if (da) begin
      exp_q.push_back(m_data(16'h8000, ad));
    end else if (db) begin
      exp_q.push_back(m_data(16'h0000, bd));
    end
  endtask

  task automatic offer(input bit dc, input logic [1:0] cr, input logic cs, input logic cp,
                       input bit da, input logic [11:0] ad, input bit db, input logic [11:0] bd);
    @(posedge clk); #1;
    bus.cfg_valid = dc; bus.cfg_ref = cr; bus.cfg_spd = cs; bus.cfg_pwr = cp;
    bus.a_valid = da; bus.a_data = ad;
    bus.b_valid = db; bus.b_data = bd;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    model_offer(dc, cr, cs, cp, da, ad, db, bd);
  endtask

  task automatic wait_drain(output bit timed_out);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 300);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    bit to;
    bit seen = 1'b0;
    bus.a_valid = 0; bus.b_valid = 0; bus.cfg_valid = 0;
    bus.a_data = '0; bus.b_data = '0; bus.cfg_ref = '0; bus.cfg_spd = 0; bus.cfg_pwr = 0;
    bus.wr_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.wr_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_valid got=%b want=0", bus.wr_valid); end
    checks++; if (bus.wr_word !== 16'h0) begin failures++; $display("FAIL rst_wr_word got=%h want=0000", bus.wr_word); end
    checks++; if (bus.init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done got=%b want=0", bus.init_done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    checks++; if ({bus.a_ready, bus.b_ready, bus.cfg_ready} !== 3'b111) begin
      failures++; $display("FAIL rst_readys got=%b want=111", {bus.a_ready, bus.b_ready, bus.cfg_ready});
    end
    model_reset();
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) begin
        seen = 1'b1;
        checks++; if (bus.init_done !== 1'b0) begin failures++; $display("FAIL init_done_early got=%b want=0", bus.init_done); end
        @(posedge clk); #1;
        checks++; if (bus.init_done !== 1'b1) begin failures++; $display("FAIL init_done_rise got=%b want=1", bus.init_done); end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL init_word_timeout got=none want=%h", exp_q[0]); end
    wait_drain(to);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL init_count got=%0d want=1", got_q.size()); end
    checks++; if (got_q.size() == 0 || got_q[0] !== 16'hD002) begin failures++; $display("FAIL init_word got=%h want=d002", got_q.size() ? got_q[0] : 16'hxxxx); end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_single();
    bit to;
    offer(0, 2'b00, 0, 0, 1, 12'h123, 0, 12'h000);
    wait_drain(to);
    offer(0, 2'b00, 0, 0, 0, 12'h000, 1, 12'h456);
    wait_drain(to);
    checks++; if (to || got_q.size() !== 2) begin failures++; $display("FAIL single_count got=%0d want=2", got_q.size()); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 16'hC123) begin failures++; $display("FAIL single_a got=%h want=c123", got_q.size() ? got_q[0] : 16'hxxxx); end
    checks++; if (got_q.size() < 2 || got_q[1] !== 16'h4456) begin failures++; $display("FAIL single_b got=%h want=4456", got_q.size() > 1 ? got_q[1] : 16'hxxxx); end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_back_to_back();
    bit to;
    int gap;
    offer(0, 2'b00, 0, 0, 1, 12'hABC, 1, 12'h321);
    wait_drain(to);
    checks++; if (to || got_q.size() !== 2) begin failures++; $display("FAIL pair_count got=%0d want=2", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL pair_word%0d got=%h want=%h", i, i < got_q.size() ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    gap = (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1;
`ifdef TLV_SCHED_PAIR_EN
    checks++; if (exp_q[0] !== 16'h5321 || gap != 1) begin failures++; $display("FAIL pair_gap got=%0d want=1", gap); end
`else
    checks++; if (exp_q[0] !== 16'hCABC || gap < 2) begin failures++; $display("FAIL rr_gap got=%0d want>=2", gap); end
`endif
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_cfg();
    bit to;
    logic [11:0] d = 12'($urandom);
    offer(1, 2'b01, 0, 0, 1, d, 0, 12'h000);
    wait_drain(to);
    checks++; if (to || got_q.size() !== 2) begin failures++; $display("FAIL cfg_count got=%0d want=2", got_q.size()); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 16'h9001) begin failures++; $display("FAIL cfg_ctrl got=%h want=9001", got_q.size() ? got_q[0] : 16'hxxxx); end
    checks++; if (got_q.size() < 2 || got_q[1] !== exp_q[1] || got_q[1][14] !== 1'b0) begin
      failures++; $display("FAIL cfg_a_word got=%h want=%h", got_q.size() > 1 ? got_q[1] : 16'hxxxx, exp_q[1]);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 30; it++) begin
      int sel = $urandom_range(1, 7);
      bit dc = (sel == 7) || ($urandom_range(0, 5) == 0);
      offer(dc, 2'($urandom), 1'($urandom), 1'($urandom),
            sel[0], 12'($urandom), sel[1], 12'($urandom));
      wait_drain(to);
      checks++; if (to || got_q.size() !== exp_q.size()) begin
        failures++; $display("FAIL rand%0d_count got=%0d want=%0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand%0d_word%0d got=%h want=%h", it, i, i < got_q.size() ? got_q[i] : 16'hxxxx, exp_q[i]);
        end
      end
      exp_q.delete(); got_q.delete(); got_cyc.delete();
    end
  endtask

  task automatic test_stall_reset();
    bit to;
    bit up = 1'b0;
    bus.wr_ready = 1'b0;
    offer(0, 2'b00, 0, 0, 1, 12'h5A5, 0, 12'h000);
    for (int i = 0; i < 20 && !up; i++) begin
      @(negedge clk);
      up = bus.wr_valid;
    end
    checks++; if (!up) begin failures++; $display("FAIL stall_valid_timeout got=0 want=1"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.wr_valid !== 1'b1 || bus.wr_word !== exp_q[0] || bus.a_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d got=%b/%h/%b want=1/%h/0", i, bus.wr_valid, bus.wr_word, bus.a_ready, exp_q[0]);
      end
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL async_rst got=%b/%b want=0/0", bus.wr_valid, bus.busy);
    end
    model_reset();
    bus.wr_ready = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    wait_drain(to);
    checks++; if (to || got_q.size() !== 1 || got_q[0] !== 16'hD002) begin
      failures++; $display("FAIL reinit got=%0d/%h want=1/d002", got_q.size(), got_q.size() ? got_q[0] : 16'hxxxx);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    offer(0, 2'b00, 0, 0, 0, 12'h000, 1, 12'h7E1);
    wait_drain(to);
    checks++; if (to || got_q.size() !== 1 || got_q[0] !== 16'h47E1) begin
      failures++; $display("FAIL post_reset_b got=%h want=47e1", got_q.size() ? got_q[0] : 16'hxxxx);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cfg();
    test_random();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
